// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: pixel/line counters, sync, DE, frame_start and DISP for an RGB LCD.
// Optional power sequencing of DISP is enabled with the macro LCD_POWERSEQ_EN.
//
// Ports:
//   clk_lcd     pixel clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   en_sync     timing enable; low holds both counters at zero
//   de_clk      pixel tick qualifier; counters advance only when high
//   disp_en     panel-on request
//   hcount_reg  horizontal position (HCW bits)
//   Vcount_reg  vertical position (VCW bits)
//   hsync       horizontal sync, active level set by SYNC_POL
//   vsync       vertical sync, active level set by SYNC_POL
//   de          data enable, high inside the active area only
//   frame_start one-cycle pulse on the tick taken at position (0,0)
//   DISP        panel display-on control
//
// Line layout: active, front porch, sync pulse, back porch; the frame uses the same
// order counted in lines. hsync/vsync/de/frame_start are registered one cycle after
// the counter values that produce them.
module lcd_timing_gen #(
  parameter int H_ACTIVE   = 480,
  parameter int H_FP       = 2,
  parameter int H_PW       = 41,
  parameter int H_BP       = 2,
  parameter int V_ACTIVE   = 272,
  parameter int V_FP       = 2,
  parameter int V_PW       = 10,
  parameter int V_BP       = 2,
  parameter int HCW        = 10,
  parameter int VCW        = 9,
  parameter int SYNC_POL   = 0,
  parameter int PWR_FRAMES = 4
) (
  input  logic           clk_lcd,
  input  logic           rst_n,
  input  logic           en_sync,
  input  logic           de_clk,
  input  logic           disp_en,
  output logic [HCW-1:0] hcount_reg,
  output logic [VCW-1:0] Vcount_reg,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           frame_start,
  output logic           DISP
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_PW + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_PW + V_BP;

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_VIS    = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_FIRST = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] HS_LAST  = HCW'(H_ACTIVE + H_FP + H_PW - 1);

  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_VIS    = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] VS_FIRST = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] VS_LAST  = VCW'(V_ACTIVE + V_FP + V_PW - 1);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  // Elaboration-time sanity checks on the geometry.
  if (H_TOTAL > (1 << HCW)) begin : g_hcw_chk
    $error("H_TOTAL does not fit HCW");
  end
  if (V_TOTAL > (1 << VCW)) begin : g_vcw_chk
    $error("V_TOTAL does not fit VCW");
  end
  if (PWR_FRAMES < 1) begin : g_pwr_chk
    $error("PWR_FRAMES must be at least 1");
  end

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic hs_on;
  logic vs_on;
  logic vis;
  logic at_origin;

  assign tick      = en_sync & de_clk;
  assign h_wrap    = (hcount_reg == H_LAST);
  assign v_wrap    = (Vcount_reg == V_LAST);
  assign hs_on     = (hcount_reg >= HS_FIRST) && (hcount_reg <= HS_LAST);
  assign vs_on     = (Vcount_reg >= VS_FIRST) && (Vcount_reg <= VS_LAST);
  assign vis       = (hcount_reg < H_VIS) && (Vcount_reg < V_VIS);
  assign at_origin = (hcount_reg == '0) && (Vcount_reg == '0);

  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      hcount_reg <= '0;
      Vcount_reg <= '0;
    end else if (!en_sync) begin
      hcount_reg <= '0;
      Vcount_reg <= '0;
    end else if (de_clk) begin
      if (h_wrap) begin
        hcount_reg <= '0;
        Vcount_reg <= v_wrap ? '0 : Vcount_reg + VCW'(1);
      end else begin
        hcount_reg <= hcount_reg + HCW'(1);
      end
    end
  end

  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_on ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= vs_on ? SYNC_ACT : ~SYNC_ACT;
      de          <= en_sync & vis;
      frame_start <= tick & at_origin;
    end
  end

`ifdef LCD_POWERSEQ_EN

  localparam int FCW = $clog2(PWR_FRAMES + 1);
  localparam logic [FCW-1:0] FRM_LAST = FCW'(PWR_FRAMES - 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAIT = 2'd1,
    ON   = 2'd2
  } pwr_t;

  pwr_t           pwr_st;
  logic [FCW-1:0] frm_cnt;

  // DISP only rises once PWR_FRAMES full frames have been started while the
  // panel request and timing were continuously on.
  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      pwr_st  <= OFF;
      frm_cnt <= '0;
      DISP    <= 1'b0;
    end else if (!disp_en || !en_sync) begin
      pwr_st  <= OFF;
      frm_cnt <= '0;
      DISP    <= 1'b0;
    end else begin
      unique case (pwr_st)
        OFF: begin
          pwr_st  <= WAIT;
          frm_cnt <= '0;
          DISP    <= 1'b0;
        end
        WAIT: begin
          if (frame_start) begin
            if (frm_cnt == FRM_LAST) begin
              pwr_st <= ON;
              DISP   <= 1'b1;
            end else begin
              frm_cnt <= frm_cnt + FCW'(1);
            end
          end
        end
        ON: begin
          DISP <= 1'b1;
        end
        default: begin
          pwr_st  <= OFF;
          frm_cnt <= '0;
          DISP    <= 1'b0;
        end
      endcase
    end
  end

`else

  always_ff @(posedge clk_lcd or negedge rst_n) begin
    if (!rst_n) begin
      DISP <= 1'b0;
    end else begin
      DISP <= disp_en;
    end
  end

`endif

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- H_ACTIVE, 480, visible pixels per line
- H_FP, 2, horizontal front porch in pixel ticks
- H_PW, 41, hsync pulse width in pixel ticks
- H_BP, 2, horizontal back porch in pixel ticks
- V_ACTIVE, 272, visible lines per frame
- V_FP, 2, vertical front porch in lines
- V_PW, 10, vsync pulse width in lines
- V_BP, 2, vertical back porch in lines
- HCW, 10, horizontal counter width
- VCW, 9, vertical counter width
- SYNC_POL, 0, sync active level (0 = active-low)
- PWR_FRAMES, 4, full frames before DISP asserts (power sequencing only)

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_lcd, in, 1, pixel clock; all logic on its rising edge
- rst_n, in, 1, asynchronous active-low reset
- en_sync, in, 1, timing enable; 0 holds counters at zero
- de_clk, in, 1, pixel tick qualifier; counters advance only when 1
- disp_en, in, 1, panel on request
- hcount_reg, out, HCW, horizontal position
- Vcount_reg, out, VCW, vertical position
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- de, out, 1, data enable; high in active area only
- frame_start, out, 1, one-cycle pulse at start of each frame
- DISP, out, 1, panel display-on control

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_PW+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_PW+V_BP SHALL fit HCW/VCW; defaults give 525 and 286.
REQ-004 hcount_reg SHALL increment by 1 on each clk_lcd edge where en_sync=1 and de_clk=1, wrapping from H_TOTAL-1 to 0; de_clk=0 SHALL hold the count.
REQ-005 Vcount_reg SHALL increment only on the edge where hcount_reg wraps, wrapping from V_TOTAL-1 to 0.
REQ-006 en_sync=0 SHALL force both counters to 0 on the next edge; counting resumes from 0,0 when en_sync returns to 1.
REQ-007 Line order SHALL be active [0,H_ACTIVE-1], then FP, then PW, then BP; frame order SHALL be the same using the V_* parameters.
REQ-008 hsync, vsync, de and frame_start SHALL be registered with one clk_lcd latency from the counter values that produce them.
REQ-009 hsync SHALL equal SYNC_POL's active level while hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_PW-1], and be inactive otherwise; vsync SHALL follow the same rule on Vcount_reg.
REQ-010 de SHALL be 1 iff hcount<H_ACTIVE and Vcount<V_ACTIVE and en_sync=1.
REQ-011 frame_start SHALL pulse for exactly one cycle when the counters are (0,0) and a tick occurs (en_sync=1, de_clk=1).

Reset
REQ-012 rst_n=0 SHALL asynchronously clear the counters, de, frame_start and DISP, set hsync/vsync to their inactive level, and set the power FSM to OFF.
REQ-013 After rst_n deasserts, the first count SHALL occur on the first qualifying edge.

Configuration
REQ-014 Macro LCD_POWERSEQ_EN defined: DISP SHALL be driven by an FSM with states OFF, WAIT, ON.
- OFF->WAIT when disp_en=1 and en_sync=1; the frame counter clears.
- WAIT->ON after PWR_FRAMES frame_start pulses.
- Any state->OFF when disp_en=0 or en_sync=0; DISP=0 on the next edge.
- DISP=1 only in ON.
REQ-015 Macro LCD_POWERSEQ_EN undefined: DISP SHALL be disp_en registered with one cycle latency, and no FSM SHALL be built.

Verification
REQ-016 Defaults, en_sync=1, de_clk=1 -> hcount wraps 524->0, Vcount wraps 285->0, de high for 480 ticks per line on lines 0-271 only.
REQ-017 SYNC_POL=0 -> hsync low for exactly 41 ticks starting one cycle after hcount=482; vsync low for lines 274-283.
REQ-018 de_clk toggling 1/0 -> counts advance only on de_clk=1 edges; line period is 1050 clk_lcd cycles.
REQ-019 en_sync dropped mid-frame at (300,100) -> counters 0,0 next edge, de=0, DISP=0 with LCD_POWERSEQ_EN.
REQ-020 LCD_POWERSEQ_EN, disp_en raised -> DISP=1 after the 4th frame_start; disp_en lowered -> DISP=0 next edge; rst_n pulsed mid-line -> all outputs at reset values immediately.
